async_fifo1: RTL and testbench
==============================

ASYNC_FIFO1 -- requirements
Module: async_fifo1

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, which is the data word width in bits.
REQ-002 The block SHALL have parameter ADDRSIZE, default 4, which is the address width; depth is 2**ADDRSIZE (16 words).
REQ-003 Clocking and reset SHALL be one clock per domain; reset is asynchronous and active-low in each domain.
REQ-004 wclk  input  1  write-domain clock, rising edge.
REQ-005 wrst_n  input  1  write-domain reset, asynchronous, active-low.
REQ-006 rclk  input  1  read-domain clock, rising edge; asynchronous to wclk.
REQ-007 rrst_n  input  1  read-domain reset, asynchronous, active-low.
REQ-008 winc  input  1  write request, sampled on wclk rise.
REQ-009 wdata  input  DATASIZE  write data, sampled with winc.
REQ-010 wfull  output  1  FIFO full, registered in the wclk domain.
REQ-011 rinc  input  1  read (pop) request, sampled on rclk rise.
REQ-012 rdata  output  DATASIZE  head-of-FIFO word, combinationally read from storage at the current read address (show-ahead).
REQ-013 rempty  output  1  FIFO empty, registered in the rclk domain.

Function
REQ-014 Storage SHALL be a 2**ADDRSIZE x DATASIZE dual-port array: synchronous write on wclk, asynchronous read.
REQ-015 On wclk rise with winc=1 and wfull=0, the array SHALL store wdata at waddr, and the write pointer SHALL increment by 1.
REQ-016 On wclk rise with winc=1 and wfull=1, the write SHALL be dropped; the array and pointer SHALL be unchanged.
REQ-017 On rclk rise with rinc=1 and rempty=0, the read pointer SHALL increment by 1.
REQ-018 On rclk rise with rinc=1 and rempty=1, the read SHALL be ignored.
REQ-019 Each pointer SHALL be ADDRSIZE+1 bits; the low ADDRSIZE bits address the array, and the MSB is a wrap flag; pointers wrap modulo 2**(ADDRSIZE+1).
REQ-020 Each pointer SHALL be kept as binary plus a registered Gray code (gray = bin ^ (bin>>1)); only the Gray value crosses domains.
REQ-021 The write Gray pointer SHALL reach rclk through a 2-flop synchronizer reset by rrst_n.
REQ-022 The read Gray pointer SHALL reach wclk through a 2-flop synchronizer reset by wrst_n.
REQ-023 rempty SHALL register (next read Gray == synchronized write Gray).
REQ-024 wfull SHALL register (next write Gray == synchronized read Gray with its two MSBs inverted).
REQ-025 rdata SHALL always equal mem[raddr]; when rempty=0 it is the oldest unread word, and it is valid before the rinc edge that pops it.
REQ-026 Data SHALL be returned in exact write order; no loss or duplication; both sides may act on the same instant.
REQ-027 rempty deassertion latency after the first write SHALL be 2-3 rclk rises (synchronizer + flag register); it SHALL never deassert while no data is present.
REQ-028 wfull deassertion latency after a pop from full SHALL be 2-3 wclk rises; it SHALL never be low while 16 words are stored (pessimistic flags only).
REQ-029 The FIFO SHALL accept exactly 16 words from empty before wfull asserts; wfull SHALL assert on the same wclk edge that accepts word 16.
REQ-030 rempty SHALL assert on the same rclk edge that pops the last word.

Reset
REQ-031 wrst_n low SHALL asynchronously clear the write binary/Gray pointers, the read-to-write synchronizer and wfull (wfull=0).
REQ-032 rrst_n low SHALL asynchronously clear the read binary/Gray pointers, the write-to-read synchronizer and rempty (rempty=1).
REQ-033 Array contents SHALL not be reset; rdata is don't-care while rempty=1.
REQ-034 Both resets SHALL be asserted together to flush the FIFO; asserting only one reset mid-operation is unsupported and leaves the occupancy undefined until both have been reset.

Verification
REQ-035 Reset both sides for 5 cycles -> wfull=0, rempty=1; rinc=1 pulses -> no pointer motion, rempty stays 1.
REQ-036 Write 0xA5 once (wclk 66.66 ns period, rclk 100 ns period) -> rempty falls within 3 rclk rises with rdata=0xA5 before rinc; pop -> rempty=1 on that edge.
REQ-037 Write 16 words 0x00..0x0F with no reads -> wfull=1 at the 16th accept; a 17th write of 0xFF is dropped; reading 16 words returns 0x00..0x0F, then rempty=1.
REQ-038 From full, pop one word -> wfull falls within 3 wclk rises; one more write is accepted, then wfull=1 again.
REQ-039 Write and read concurrently on alternate cycles, 230 random words x 2 bursts with 1 us gaps -> every rdata matches the scoreboard in order; pointers wrap repeatedly.
REQ-040 Assert both resets mid-stream with 5 words queued -> rempty=1, wfull=0 immediately; subsequent traffic is correct from an empty state.

Source files
------------

// File: rtl/async_fifo1.sv
`timescale 1ns/10ps
// Dual-clock FIFO with show-ahead read data. Binary/Gray pointer pairs cross domains
// as Gray codes through 2-flop synchronizers; full/empty are registered and pessimistic.
module async_fifo1 #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0]   wbin, wptr, wbin_next, wgray_next, wq1_rptr, wq2_rptr;
  logic [ADDRSIZE:0]   rbin, rptr, rbin_next, rgray_next, rq1_wptr, rq2_wptr;
  logic [ADDRSIZE-1:0] waddr, raddr;
  logic                wfull_next, rempty_next;

  // NOTE: the storage array is deliberately left without reset; only pointers and
  // flags define occupancy, and a resettable array would not map onto RAM.
  always_ff @(posedge wclk) begin
    if (winc && !wfull) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  // ---------------- write domain ----------------
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbin_next  = wbin + (ADDRSIZE+1)'(winc && !wfull);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  // Full when the write pointer has lapped the read pointer: top two Gray bits differ.
  assign wfull_next = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                      wq2_rptr[ADDRSIZE-2:0]});

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wptr     <= '0;
      wq1_rptr <= '0;
      wq2_rptr <= '0;
      wfull    <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wptr     <= wgray_next;
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
      wfull    <= wfull_next;
    end
  end

  // ---------------- read domain ----------------
  assign raddr       = rbin[ADDRSIZE-1:0];
  assign rbin_next   = rbin + (ADDRSIZE+1)'(rinc && !rempty);
  assign rgray_next  = (rbin_next >> 1) ^ rbin_next;
  assign rempty_next = (rgray_next == rq2_wptr);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr     <= '0;
      rq1_wptr <= '0;
      rq2_wptr <= '0;
      rempty   <= 1'b1;
    end else begin
      rbin     <= rbin_next;
      rptr     <= rgray_next;
      rq1_wptr <= wptr;
      rq2_wptr <= rq1_wptr;
      rempty   <= rempty_next;
    end
  end

endmodule

// File: tb/tb_async_fifo1.sv
`timescale 1ns/10ps
// Directed bench for async_fifo1: reset, single word, fill/overflow, release from full,
// concurrent random bursts against an in-order scoreboard, and a mid-stream flush.
module tb_async_fifo1;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BURST = 230;

  logic          wclk = 1'b0, rclk = 1'b0;
  logic          wrst_n = 1'b0, rrst_n = 1'b0;
  logic          winc = 1'b0, rinc = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          wfull, rempty;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] sb [$];

  async_fifo1 #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  always #33.33 wclk = ~wclk;
  always #50    rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write attempt; accepted only if wfull was low going into the edge.
  task automatic push(input logic [DW-1:0] d, output bit acc);
    @(negedge wclk);
    acc   = !wfull;
    winc  = 1'b1;
    wdata = d;
    @(posedge wclk); #1;
    winc = 1'b0;
    if (acc) sb.push_back(d);
  endtask

  // Checks show-ahead data against the scoreboard head, then pops it.
  task automatic pop(input string tag);
    @(negedge rclk);
    check({tag, "_rempty"}, rempty, 1'b0);
    if (sb.size() == 0) check({tag, "_sb"}, 32'(sb.size()), 32'd1);
    else                check(tag, rdata, sb[0]);
    rinc = 1'b1;
    @(posedge rclk); #1;
    rinc = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic wait_rempty_fall(output int n);
    n = 0;
    while (rempty && n < 20) begin
      @(posedge rclk); #1;
      n++;
    end
  endtask

  task automatic wait_wfull_fall(output int n);
    n = 0;
    while (wfull && n < 20) begin
      @(posedge wclk); #1;
      n++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, wr_acc, rd_go;
    int n, nrd, nwr;

    // Reset both domains together
    repeat (5) @(posedge rclk);
    #1;
    check("rst_wfull", wfull, 1'b0);
    check("rst_rempty", rempty, 1'b1);
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      rinc = 1'b1;
      @(posedge rclk); #1;
      rinc = 1'b0;
      check("empty_pop_rempty", rempty, 1'b1);
    end

    // Single word round trip
    push(8'hA5, acc);
    check("a5_accept", acc, 1'b1);
    wait_rempty_fall(n);
    check("a5_rempty_fall", rempty, 1'b0);
    check("a5_rempty_lat", n <= 3, 1'b1);
    pop("a5_rdata");
    check("a5_rempty_after_pop", rempty, 1'b1);

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i), acc);
      check("fill_accept", acc, 1'b1);
      check("fill_wfull", wfull, i == DEPTH - 1);
    end
    push(8'hFF, acc);
    check("ovf_dropped", acc, 1'b0);
    check("ovf_wfull", wfull, 1'b1);
    wait_rempty_fall(n);
    for (int i = 0; i < DEPTH; i++) pop("fill_rdata");
    check("drain_rempty", rempty, 1'b1);

    // Release from full by a single pop
    repeat (4) @(posedge wclk);
    #1;
    check("drained_wfull", wfull, 1'b0);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), acc);
    check("full2_wfull", wfull, 1'b1);
    check("full2_sb", 32'(sb.size()), 32'(DEPTH));
    wait_rempty_fall(n);
    pop("full2_pop");
    wait_wfull_fall(n);
    check("full2_wfull_fall", wfull, 1'b0);
    check("full2_wfull_lat", n <= 3, 1'b1);
    push(8'h5A, acc);
    check("refill_accept", acc, 1'b1);
    check("refill_wfull", wfull, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop("refill_rdata");
    check("refill_rempty", rempty, 1'b1);

    // Concurrent random bursts on alternate cycles
    repeat (4) @(posedge wclk);
    nrd = 0;
    fork
      begin : writer
        for (int b = 0; b < 2; b++) begin
          nwr = 0;
          for (int g = 0; g < 6000 && nwr < BURST; g++) begin
            @(negedge wclk);
            wr_acc = (g % 2 == 0) && !wfull;
            winc   = wr_acc;
            wdata  = 8'($urandom_range(0, 255));
            @(posedge wclk); #1;
            winc = 1'b0;
            if (wr_acc) begin
              sb.push_back(wdata);
              nwr++;
            end
          end
          check("burst_write_count", nwr, BURST);
          #1000;
        end
      end
      begin : reader
        for (int cyc = 0; cyc < 3000 && nrd < 2 * BURST; cyc++) begin
          @(negedge rclk);
          rd_go = (cyc % 2 == 0) && !rempty;
          if (rd_go) begin
            if (sb.size() == 0) check("stream_sb", 32'(sb.size()), 32'd1);
            else                check("stream_rdata", rdata, sb[0]);
            rinc = 1'b1;
          end
          @(posedge rclk); #1;
          rinc = 1'b0;
          if (rd_go) begin
            if (sb.size() != 0) void'(sb.pop_front());
            nrd++;
          end
        end
      end
    join
    check("stream_read_count", nrd, 2 * BURST);
    check("stream_rempty", rempty, 1'b1);

    // Flush with words queued
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), acc);
    wait_rempty_fall(n);
    check("flush_pre_rempty", rempty, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b0;
    rrst_n = 1'b0;
    #1;
    check("flush_rempty", rempty, 1'b1);
    check("flush_wfull", wfull, 1'b0);
    sb.delete();
    repeat (3) @(posedge rclk);
    #1;
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) push(8'(8'hE0 + i), acc);
    wait_rempty_fall(n);
    check("post_flush_rempty", rempty, 1'b0);
    for (int i = 0; i < 3; i++) pop("post_flush_rdata");
    check("post_flush_empty", rempty, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
